cbd_sampler: RTL



---
 rtl/cbd_sampler_if.sv | 10 +
 rtl/cbd_sampler.sv | 99 +++++++++
 2 files changed

// File: rtl/cbd_sampler_if.sv
// Handshake/data bundle between the noise-generation FSM (master) and cbd_sampler (slave).
interface cbd_sampler_if;
  logic          enable;
  logic [1023:0] noise;
  logic          done;
  logic [4095:0] poly_out;

  modport master (output enable, output noise, input done, input poly_out);
  modport slave  (input enable, input noise, output done, output poly_out);
endinterface

// File: rtl/cbd_sampler.sv
// Kyber eta=2 centered binomial sampler: one 1024-bit SHAKE256 block -> 256 x 16-bit coefficients.
// Build option CBD_SIGNED_COEFF_EN: emit two's complement d instead of the mod-Q form.
//
// state  | meaning
// IDLE   | waiting for first start pulse
// RUN    | writing LANES coefficients per cycle from the latched buffer
// DONE   | poly_out complete and stable; start pulse restarts
module cbd_sampler #(
  parameter int LANES = 8,
  parameter int Q     = 3329
) (
  input logic         clk,
  input logic         rst,
  cbd_sampler_if.slave bus
);

  localparam int CHUNKS = 256 / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [1023:0]         nbuf;
  logic [4095:0]         poly;
  logic                  done_q;
  logic [9:0]            nbase;
  logic [11:0]           pbase;
  logic [4*LANES-1:0]    nib;
  logic [16*LANES-1:0]   coef;

  function automatic logic [15:0] cbd_coef(input logic [3:0] n);
    logic [1:0]  a;
    logic [1:0]  b;
    logic [15:0] r;
    a = {1'b0, n[0]} + {1'b0, n[1]};
    b = {1'b0, n[2]} + {1'b0, n[3]};
    if (a >= b) begin
      r = {14'd0, a - b};
    end else begin
`ifdef CBD_SIGNED_COEFF_EN
      r = 16'd0 - {14'd0, b - a};
`else
      r = 16'(Q) - {14'd0, b - a};
`endif
    end
    return r;
  endfunction

  // Chunk offsets are power-of-two multiples of the counter, so a shift replaces the multiply.
  assign nbase = 10'(cnt) << $clog2(4 * LANES);
  assign pbase = 12'(cnt) << $clog2(16 * LANES);
  assign nib   = nbuf[nbase +: 4*LANES];

  always_comb begin
    coef = '0;
    for (int l = 0; l < LANES; l++) begin
      coef[16*l +: 16] = cbd_coef(nib[4*l +: 4]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      nbuf   <= '0;
      poly   <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.enable) begin
            nbuf   <= bus.noise;
            cnt    <= '0;
            done_q <= 1'b0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          // Only the current chunk is written; a restart leaves later chunks at old values.
          poly[pbase +: 16*LANES] <= coef;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.done     = done_q;
  assign bus.poly_out = poly;

endmodule
